// File: rtl/exec_pkg.sv
// Shared types and EX/MEM buffer field layout for the execute stage.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_MUL   = 4'd8,
        ALU_SLT   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_PCIMM = 4'd11,
        ALU_RSV12 = 4'd12,
        ALU_RSV13 = 4'd13,
        ALU_RSV14 = 4'd14,
        ALU_RSV15 = 4'd15
    } alu_op_e;

    localparam int BUF_W       = 82;
    localparam int RES_LSB     = 0;
    localparam int RES_W       = 32;
    localparam int STD_LSB     = 32;
    localparam int STD_W       = 32;
    localparam int REGID_W     = 4;
    localparam int RC_LSB      = 64;
    localparam int RA_LSB      = 68;
    localparam int RB_LSB      = 72;
    localparam int REGWR_BIT   = 76;
    localparam int MEM2REG_BIT = 77;
    localparam int MEMWR_BIT   = 78;
    localparam int BRTAKEN_BIT = 79;
    localparam int ZERO_BIT    = 80;
    localparam int NEG_BIT     = 81;

endpackage

// File: rtl/exec_if.sv
// Execute-stage bus: decoded operands/control in, EX/MEM buffer out.
interface exec_if #(
    parameter int N = 32
);
    import exec_pkg::*;

    logic                en;
    logic signed [N-1:0] rd1;
    logic signed [N-1:0] rd2;
    logic signed [N-1:0] pc;
    logic signed [N-1:0] imm;
    logic signed [N-1:0] aluOut;
    logic signed [N-1:0] result;
    logic signed [N-1:0] rd3;
    logic [3:0]          aluControl;
    logic [3:0]          Ra;
    logic [3:0]          Rb;
    logic [3:0]          Rc;
    logic                immSrc;
    logic                branchFlag;
    logic                memWrite;
    logic                memToReg;
    logic                regWrite;
    logic                Fa;
    logic                Fb;
    logic [BUF_W-1:0]    bufferOut;

    modport master (
        output en, rd1, rd2, pc, imm, aluOut, result, rd3, aluControl,
               Ra, Rb, Rc, immSrc, branchFlag, memWrite, memToReg, regWrite, Fa, Fb,
        input  bufferOut
    );

    modport slave (
        input  en, rd1, rd2, pc, imm, aluOut, result, rd3, aluControl,
               Ra, Rb, Rc, immSrc, branchFlag, memWrite, memToReg, regWrite, Fa, Fb,
        output bufferOut
    );

endinterface

// File: rtl/exec_alu.sv
// Combinational N-bit ALU with zero/negative flags.
// Multiply is only built when EXEC_MUL_EN is defined; otherwise opcode 8 yields 0.
module exec_alu
    import exec_pkg::*;
#(
    parameter int N = 32
) (
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_i,
    input  logic signed [N-1:0] pc_i,
    input  logic signed [N-1:0] imm_i,
    input  alu_op_e             op_i,
    output logic signed [N-1:0] result_o,
    output logic                zero_o,
    output logic                negative_o
);

    logic                shamt_big_s;
    logic signed [N-1:0] mul_s;
    logic signed [N-1:0] res_s;

    // Shift amount is B as unsigned; anything >= N saturates the shift.
    always_comb begin
        shamt_big_s = ({1'b0, b_i} >= (N+1)'(N));
    end

    // Optional multiplier, low N bits only.
    always_comb begin
`ifdef EXEC_MUL_EN
        mul_s = a_i * b_i;
`else
        mul_s = {N{1'b0}};
`endif
    end

    // Opcode decode.
    always_comb begin
        res_s = {N{1'b0}};
        case (op_i)
            ALU_ADD:   res_s = a_i + b_i;
            ALU_SUB:   res_s = a_i - b_i;
            ALU_AND:   res_s = a_i & b_i;
            ALU_OR:    res_s = a_i | b_i;
            ALU_XOR:   res_s = a_i ^ b_i;
            ALU_SLL:   res_s = shamt_big_s ? {N{1'b0}} : (a_i << b_i);
            ALU_SRL:   res_s = shamt_big_s ? {N{1'b0}} : signed'($unsigned(a_i) >> b_i);
            ALU_SRA:   res_s = shamt_big_s ? {N{a_i[N-1]}} : (a_i >>> b_i);
            ALU_MUL:   res_s = mul_s;
            ALU_SLT:   res_s = (a_i < b_i) ? {{(N-1){1'b0}}, 1'b1} : {N{1'b0}};
            ALU_PASSB: res_s = b_i;
            ALU_PCIMM: res_s = pc_i + imm_i;
            default:   res_s = {N{1'b0}};
        endcase
    end

    // Result and flags.
    always_comb begin
        result_o   = res_s;
        zero_o     = (res_s == {N{1'b0}});
        negative_o = res_s[N-1];
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand forwarding muxes, ALU, branch compare and the
// registered 82-bit EX/MEM buffer. Optional multiplier: EXEC_MUL_EN.
module exec_stage
    import exec_pkg::*;
#(
    parameter int N = 32
) (
    input  logic   clk,
    input  logic   rst,
    exec_if.slave  bus
);

    logic signed [N-1:0] a_s;
    logic signed [N-1:0] bf_s;
    logic signed [N-1:0] b_s;
    logic signed [N-1:0] alu_res_s;
    logic                alu_zero_s;
    logic                alu_neg_s;
    logic                br_taken_s;
    logic [BUF_W-1:0]    buffer_d;
    logic [BUF_W-1:0]    buffer_q;

    // Forwarding and immediate selection; the branch compare sees Bf, not B.
    always_comb begin
        a_s        = bus.Fa ? bus.aluOut : bus.rd1;
        bf_s       = bus.Fb ? bus.result : bus.rd2;
        b_s        = bus.immSrc ? bus.imm : bf_s;
        br_taken_s = bus.branchFlag & (a_s == bf_s);
    end

    exec_alu #(.N(N)) u_alu (
        .a_i        (a_s),
        .b_i        (b_s),
        .pc_i       (bus.pc),
        .imm_i      (bus.imm),
        .op_i       (alu_op_e'(bus.aluControl)),
        .result_o   (alu_res_s),
        .zero_o     (alu_zero_s),
        .negative_o (alu_neg_s)
    );

    // Pack the next buffer value; N-bit values are sign-extended to 32.
    always_comb begin
        buffer_d                            = {BUF_W{1'b0}};
        buffer_d[RES_LSB +: RES_W]          = 32'(alu_res_s);
        buffer_d[STD_LSB +: STD_W]          = 32'(bus.rd3);
        buffer_d[RC_LSB +: REGID_W]         = bus.Rc;
        buffer_d[RA_LSB +: REGID_W]         = bus.Ra;
        buffer_d[RB_LSB +: REGID_W]         = bus.Rb;
        buffer_d[REGWR_BIT]                 = bus.regWrite;
        buffer_d[MEM2REG_BIT]               = bus.memToReg;
        buffer_d[MEMWR_BIT]                 = bus.memWrite;
        buffer_d[BRTAKEN_BIT]               = br_taken_s;
        buffer_d[ZERO_BIT]                  = alu_zero_s;
        buffer_d[NEG_BIT]                   = alu_neg_s;
    end

    // EX/MEM register; reset wins over stall so a bubble is inserted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buffer_q <= {BUF_W{1'b0}};
        end else if (bus.en) begin
            buffer_q <= buffer_d;
        end
    end

    assign bus.bufferOut = buffer_q;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage at N=4: per-cycle reference model plus
// directed vectors with hand-computed expectations.
module tb_exec_stage;

    localparam int N = 4;

    logic clk;
    logic rst;

    exec_if #(.N(N)) ifc ();

    exec_stage #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int checks;
    int errors;

    logic [81:0] exp_q;
    logic        exp_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [81:0] act, input logic [81:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: evaluate the ALU rules on plain ints, wrap to N bits, then pack.
    function automatic logic [81:0] model();
        int a, bf, b, amt, r, w, s;
        logic [81:0] v;
        a   = ifc.Fa ? int'(ifc.aluOut) : int'(ifc.rd1);
        bf  = ifc.Fb ? int'(ifc.result) : int'(ifc.rd2);
        b   = ifc.immSrc ? int'(ifc.imm) : bf;
        amt = b & ((1 << N) - 1);
        case (int'(ifc.aluControl))
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (amt >= N) ? 0 : (a << amt);
            6: r = (amt >= N) ? 0 : ((a & ((1 << N) - 1)) >> amt);
            7: r = (amt >= N) ? ((a < 0) ? -1 : 0) : (a >>> amt);
`ifdef EXEC_MUL_EN
            8: r = a * b;
`else
            8: r = 0;
`endif
            9: r = (a < b) ? 1 : 0;
            10: r = b;
            11: r = int'(ifc.pc) + int'(ifc.imm);
            default: r = 0;
        endcase
        w = r & ((1 << N) - 1);
        s = (w >= (1 << (N - 1))) ? (w - (1 << N)) : w;
        v        = '0;
        v[31:0]  = s;
        v[63:32] = int'(ifc.rd3);
        v[67:64] = ifc.Rc;
        v[71:68] = ifc.Ra;
        v[75:72] = ifc.Rb;
        v[76]    = ifc.regWrite;
        v[77]    = ifc.memToReg;
        v[78]    = ifc.memWrite;
        v[79]    = ifc.branchFlag & (a == bf);
        v[80]    = (w == 0);
        v[81]    = (s < 0);
        return v;
    endfunction

    // Track what the buffer must hold after each edge.
    always @(posedge clk) begin
        if (!rst) begin
            exp_q     <= '0;
            exp_valid <= 1'b1;
        end else if (ifc.en) begin
            exp_q <= model();
        end
    end

    // Compare every cycle once the buffer is defined.
    always @(negedge clk) begin
        if (exp_valid) chk("model", ifc.bufferOut, exp_q);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.en = 1'b1; ifc.rd1 = '0; ifc.rd2 = '0; ifc.pc = '0; ifc.imm = '0;
        ifc.aluOut = '0; ifc.result = '0; ifc.rd3 = '0; ifc.aluControl = 4'd0;
        ifc.Ra = 4'd0; ifc.Rb = 4'd0; ifc.Rc = 4'd0; ifc.immSrc = 1'b0;
        ifc.branchFlag = 1'b0; ifc.memWrite = 1'b0; ifc.memToReg = 1'b0;
        ifc.regWrite = 1'b0; ifc.Fa = 1'b0; ifc.Fb = 1'b0;
    endtask

    logic [81:0] held;

    initial begin
        checks = 0; errors = 0; exp_valid = 1'b0; exp_q = '0;
        rst = 1'b0;
        clear_inputs();

        // Reset, then first ADD
        ifc.rd1 = 4'sd2; ifc.rd2 = 4'sd2; ifc.Ra = 4'd1; ifc.Rb = 4'd2; ifc.Rc = 4'd3;
        tick();
        chk("reset", ifc.bufferOut, 82'd0);
        rst = 1'b1;
        tick();
        chk("add_res", 82'(ifc.bufferOut[31:0]), 82'h4);
        chk("add_zero", 82'(ifc.bufferOut[80]), 82'd0);
        chk("ids", 82'(ifc.bufferOut[75:64]), 82'h213);

        // SUB and branch compare
        ifc.aluControl = 4'd1; ifc.branchFlag = 1'b1;
        tick();
        chk("sub_zero", 82'({ifc.bufferOut[80:79], ifc.bufferOut[31:0]}), 82'h3_0000_0000);
        ifc.rd2 = 4'sd3;
        tick();
        chk("sub_neg", 82'({ifc.bufferOut[81:79], ifc.bufferOut[31:0]}), 82'h4_FFFF_FFFF);

        // Overflow wrap
        ifc.aluControl = 4'd0; ifc.branchFlag = 1'b0; ifc.rd1 = 4'sd7; ifc.rd2 = 4'sd1;
        tick();
        chk("wrap", 82'({ifc.bufferOut[81], ifc.bufferOut[31:0]}), 82'h1_FFFF_FFF8);

        // Forwarding and immediate
        ifc.Fa = 1'b1; ifc.aluOut = 4'sd5; ifc.rd1 = 4'sd2; ifc.rd2 = 4'sd2;
        tick();
        chk("fwd_a", 82'(ifc.bufferOut[31:0]), 82'h7);
        ifc.Fa = 1'b0; ifc.Fb = 1'b1; ifc.result = -4'sd3;
        tick();
        chk("fwd_b", 82'(ifc.bufferOut[31:0]), 82'hFFFF_FFFF);
        ifc.Fb = 1'b0; ifc.immSrc = 1'b1; ifc.imm = 4'sd1; ifc.branchFlag = 1'b1;
        tick();
        chk("imm_br", 82'({ifc.bufferOut[79], ifc.bufferOut[31:0]}), 82'h1_0000_0003);

        // Stall holds through input changes, then reset bubbles even when stalled
        held = ifc.bufferOut;
        ifc.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifc.rd1 = 4'(i + 3); ifc.aluControl = 4'(i + 2); ifc.Rc = 4'(i + 9);
            ifc.regWrite = ~ifc.regWrite;
            tick();
            chk("stall", ifc.bufferOut, held);
        end
        rst = 1'b0;
        tick();
        chk("rst_stall", ifc.bufferOut, 82'd0);
        rst = 1'b1;
        clear_inputs();

        // Shifts and passthrough
        ifc.aluControl = 4'd7; ifc.rd1 = -4'sd8; ifc.rd2 = 4'sd5;
        tick();
        chk("sra_big", 82'(ifc.bufferOut[31:0]), 82'hFFFF_FFFF);
        ifc.aluControl = 4'd5; ifc.rd1 = 4'sd3; ifc.rd2 = 4'sd4;
        tick();
        chk("sll_big", 82'({ifc.bufferOut[80], ifc.bufferOut[31:0]}), 82'h1_0000_0000);
        ifc.rd2 = 4'sd2;
        tick();
        chk("sll_2", 82'(ifc.bufferOut[31:0]), 82'hFFFF_FFFC);
        ifc.aluControl = 4'd6; ifc.rd1 = -4'sd8; ifc.rd2 = 4'sd1;
        tick();
        chk("srl_1", 82'(ifc.bufferOut[31:0]), 82'h4);
        ifc.memWrite = 1'b1; ifc.memToReg = 1'b1; ifc.regWrite = 1'b1; ifc.rd3 = 4'sd3;
        tick();
        chk("ctrl", 82'({ifc.bufferOut[78:76], ifc.bufferOut[63:32]}), 82'h7_0000_0003);
        ifc.rd3 = -4'sd2;
        tick();
        chk("st_neg", 82'(ifc.bufferOut[63:32]), 82'hFFFF_FFFE);

        // Remaining opcodes
        ifc.aluControl = 4'd9; ifc.rd1 = -4'sd8; ifc.rd2 = 4'sd7;
        tick();
        chk("slt_t", 82'(ifc.bufferOut[31:0]), 82'h1);
        ifc.rd1 = 4'sd3; ifc.rd2 = -4'sd1;
        tick();
        chk("slt_f", 82'(ifc.bufferOut[31:0]), 82'h0);
        ifc.aluControl = 4'd11; ifc.pc = 4'sd3; ifc.imm = 4'sd2;
        tick();
        chk("pcimm", 82'(ifc.bufferOut[31:0]), 82'h5);
        ifc.aluControl = 4'd4; ifc.rd1 = 4'sd5; ifc.rd2 = 4'sd3;
        tick();
        chk("xor", 82'(ifc.bufferOut[31:0]), 82'h6);
        ifc.aluControl = 4'd8; ifc.rd1 = 4'sd3; ifc.rd2 = 4'sd3;
        tick();
`ifdef EXEC_MUL_EN
        chk("mul", 82'(ifc.bufferOut[31:0]), 82'hFFFF_FFF9);
`else
        chk("mul_off", 82'({ifc.bufferOut[81:80], ifc.bufferOut[31:0]}), 82'h1_0000_0000);
`endif
        ifc.aluControl = 4'd13;
        tick();
        chk("rsv", 82'(ifc.bufferOut[31:0]), 82'h0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
